// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the write responder state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Word-addressed register bank with per-byte strobe merge and an out-of-range flag.
module axi_lite_reg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_we,
    input  logic [IDX_W-1:0]           i_idx,
    input  logic [DATA_W-1:0]          i_data,
    input  logic [DATA_W/8-1:0]        i_strb,
    output logic [NUM_REGS*DATA_W-1:0] o_reg_q,
    output logic                       o_oor
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    assign o_oor = (32'(i_idx) >= 32'(NUM_REGS));

    // An out-of-range index matches no register, so such writes fall through untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_idx == IDX_W'(i)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (i_strb[b]) begin
                            r_regs[i][b*8 +: 8] <= i_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign o_reg_q[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

endmodule

// File: rtl/axi_lite_wr_responder.sv
// AXI-Lite write responder: independent AW/W capture, one-cycle commit into the bank, held B response.
module axi_lite_wr_responder
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic                       wr_done,
    output state_t                     dbg_state
);

    // Handshake rule on every channel: a transfer happens at a rising edge where
    // valid && ready are both 1; ready is registered and never looks at valid.

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = ADDR_W - 2;

    state_t              r_state,   w_state_nxt;
    logic                r_awready, w_awready_nxt;
    logic                r_wready,  w_wready_nxt;
    logic                r_bvalid,  w_bvalid_nxt;
    logic [1:0]          r_bresp,   w_bresp_nxt;
    logic                r_wr_done, w_wr_done_nxt;
    logic                r_aw_have, w_aw_have_nxt;
    logic                r_w_have,  w_w_have_nxt;
    logic [IDX_W-1:0]    r_idx,     w_idx_nxt;
    logic [DATA_W-1:0]   r_data,    w_data_nxt;
    logic [STRB_W-1:0]   r_strb,    w_strb_nxt;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_bank_we;
    logic w_oor;
    logic w_unused_addr_lsb;

    assign w_aw_hs = awvalid && r_awready;
    assign w_w_hs  = wvalid && r_wready;
    // Byte offset within a word carries no meaning here.
    assign w_unused_addr_lsb = ^awaddr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wr_done <= 1'b0;
            r_aw_have <= 1'b0;
            r_w_have  <= 1'b0;
            r_idx     <= '0;
            r_data    <= '0;
            r_strb    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_wr_done <= w_wr_done_nxt;
            r_aw_have <= w_aw_have_nxt;
            r_w_have  <= w_w_have_nxt;
            r_idx     <= w_idx_nxt;
            r_data    <= w_data_nxt;
            r_strb    <= w_strb_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_wr_done_nxt = 1'b0;
        w_aw_have_nxt = r_aw_have;
        w_w_have_nxt  = r_w_have;
        w_idx_nxt     = r_idx;
        w_data_nxt    = r_data;
        w_strb_nxt    = r_strb;
        w_bank_we     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_aw_hs) begin
                    w_aw_have_nxt = 1'b1;
                    w_idx_nxt     = awaddr[ADDR_W-1:2];
                end
                if (w_w_hs) begin
                    w_w_have_nxt = 1'b1;
                    w_data_nxt   = wdata;
                    w_strb_nxt   = wstrb;
                end
                // Also raises both readies on the first edge out of reset.
                w_awready_nxt = !(r_aw_have || w_aw_hs);
                w_wready_nxt  = !(r_w_have || w_w_hs);
                if ((r_aw_have || w_aw_hs) && (r_w_have || w_w_hs)) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_bank_we     = 1'b1;
                w_wr_done_nxt = 1'b1;
                w_bvalid_nxt  = 1'b1;
                w_bresp_nxt   = w_oor ? RESP_SLVERR : RESP_OKAY;
                w_aw_have_nxt = 1'b0;
                w_w_have_nxt  = 1'b0;
                w_state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                if (bready) begin
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    axi_lite_reg_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_bank_we),
        .i_idx   (r_idx),
        .i_data  (r_data),
        .i_strb  (r_strb),
        .o_reg_q (reg_q),
        .o_oor   (w_oor)
    );

    assign awready   = r_awready;
    assign wready    = r_wready;
    assign bvalid    = r_bvalid;
    assign bresp     = r_bresp;
    assign wr_done   = r_wr_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_axi_lite_wr_responder.sv
// Directed bench for axi_lite_wr_responder: vector table plus backpressure and reset sequences.
module tb_axi_lite_wr_responder;
    import axi_lite_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [127:0] reg_q;
    logic         wr_done;
    state_t       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]   addr;
        logic [31:0]  data;
        logic [3:0]   strb;
        int           aw_dly;
        int           w_dly;
        logic [1:0]   exp_resp;
        logic [127:0] exp_q;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    axi_lite_wr_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .reg_q     (reg_q),
        .wr_done   (wr_done),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs;
        bit w_hs;
        int cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            awaddr  = v.addr;
            wdata   = v.data;
            wstrb   = v.strb;
            awvalid = !aw_done && (cyc >= v.aw_dly);
            wvalid  = !w_done && (cyc >= v.w_dly);
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            if (w_done && !aw_done) check({tag, "_wready_hold"}, 128'(wready), 128'd0);
            if (aw_done && !w_done) check({tag, "_awready_hold"}, 128'(awready), 128'd0);
            tick();
            cyc++;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done  = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check({tag, "_hs_timeout"}, 128'd0, 128'd1);
            return;
        end
        check({tag, "_commit_bvalid"}, 128'(bvalid), 128'd0);
        check({tag, "_commit_awready"}, 128'(awready), 128'd0);
        tick();
        check({tag, "_bvalid"}, 128'(bvalid), 128'd1);
        check({tag, "_wr_done"}, 128'(wr_done), 128'd1);
        check({tag, "_bresp"}, 128'(bresp), 128'(v.exp_resp));
        check({tag, "_reg_q"}, reg_q, v.exp_q);
        tick();
        check({tag, "_wr_done_clr"}, 128'(wr_done), 128'd0);
        check({tag, "_bvalid_clr"}, 128'(bvalid), 128'd0);
        check({tag, "_readies"}, 128'({awready, wready}), 128'd3);
    endtask

    initial begin
        vecs[0] = '{8'h04, 32'hDEADBEEF, 4'hF, 0, 0, RESP_OKAY,
                    128'h00000000_00000000_DEADBEEF_00000000};
        vecs[1] = '{8'h04, 32'h000000AA, 4'b0001, 5, 0, RESP_OKAY,
                    128'h00000000_00000000_DEADBEAA_00000000};
        vecs[2] = '{8'h10, 32'h12345678, 4'hF, 0, 0, RESP_SLVERR,
                    128'h00000000_00000000_DEADBEAA_00000000};
        vecs[3] = '{8'h0B, 32'hA5A5A5A5, 4'b1010, 1, 1, RESP_OKAY,
                    128'h00000000_A500A500_DEADBEAA_00000000};
        vecs[4] = '{8'h0C, 32'h11223344, 4'hF, 0, 3, RESP_OKAY,
                    128'h11223344_A500A500_DEADBEAA_00000000};
        vecs[5] = '{8'h00, 32'hFFFFFFFF, 4'h0, 0, 0, RESP_OKAY,
                    128'h11223344_A500A500_DEADBEAA_00000000};
        vecs[6] = '{8'hFC, 32'h87654321, 4'hF, 2, 0, RESP_SLVERR,
                    128'h11223344_A500A500_DEADBEAA_00000000};
        vecs[7] = '{8'h00, 32'hCAFEF00D, 4'b0110, 0, 0, RESP_OKAY,
                    128'h11223344_A500A500_DEADBEAA_00FEF000};

        rst_n   = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;

        // Reset and release
        repeat (3) tick();
        check("rst_awready", 128'(awready), 128'd0);
        check("rst_wready", 128'(wready), 128'd0);
        check("rst_bvalid", 128'(bvalid), 128'd0);
        check("rst_bresp", 128'(bresp), 128'd0);
        check("rst_wr_done", 128'(wr_done), 128'd0);
        check("rst_reg_q", reg_q, 128'd0);
        rst_n = 1'b1;
        check("rel_awready_pre", 128'(awready), 128'd0);
        tick();
        check("rel_awready", 128'(awready), 128'd1);
        check("rel_wready", 128'(wready), 128'd1);
        check("rel_bvalid", 128'(bvalid), 128'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: B held, second AW waits
        bready  = 1'b0;
        awaddr  = 8'h08;
        wdata   = 32'h0F0F0F0F;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        tick();
        check("bp_bvalid", 128'(bvalid), 128'd1);
        check("bp_reg_q", reg_q, 128'h11223344_0F0F0F0F_DEADBEAA_00FEF000);
        awaddr  = 8'h0C;
        awvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp_hold_bvalid_%0d", c), 128'(bvalid), 128'd1);
            check($sformatf("bp_hold_bresp_%0d", c), 128'(bresp), 128'(RESP_OKAY));
            check($sformatf("bp_hold_readies_%0d", c), 128'({awready, wready}), 128'd0);
        end
        bready = 1'b1;
        tick();
        check("bp_b_done", 128'(bvalid), 128'd0);
        check("bp_aw_pending", 128'(awready), 128'd1);
        tick();
        check("bp_aw_taken", 128'(awready), 128'd0);
        check("bp_w_open", 128'(wready), 128'd1);
        awvalid = 1'b0;
        wdata   = 32'h00000055;
        wstrb   = 4'b0001;
        wvalid  = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        check("bp2_bvalid", 128'(bvalid), 128'd1);
        check("bp2_wr_done", 128'(wr_done), 128'd1);
        check("bp2_reg_q", reg_q, 128'h11223355_0F0F0F0F_DEADBEAA_00FEF000);
        tick();
        check("bp2_bvalid_clr", 128'(bvalid), 128'd0);

        // Reset while waiting in RESP
        bready  = 1'b0;
        awaddr  = 8'h00;
        wdata   = 32'h12345678;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        tick();
        check("mr_bvalid_pre", 128'(bvalid), 128'd1);
        check("mr_reg_q_pre", reg_q, 128'h11223355_0F0F0F0F_DEADBEAA_12345678);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mr_bvalid", 128'(bvalid), 128'd0);
        check("mr_reg_q", reg_q, 128'd0);
        check("mr_readies", 128'({awready, wready}), 128'd0);
        check("mr_wr_done", 128'(wr_done), 128'd0);
        tick();
        rst_n  = 1'b1;
        bready = 1'b1;
        tick();
        check("mr_rel_readies", 128'({awready, wready}), 128'd3);
        check("mr_rel_bvalid", 128'(bvalid), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
